// File: rtl/voice_mix.sv
// ============================================================================
// Module      : voice_mix
// Description : Multi-voice PCM mixer; envelope-scales one voice per cycle,
//               then shifts and reduces the sum. Optional: VOICE_MIX_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_mix #(
    parameter int PCM_W      = 16,
    parameter int VOICES     = 4,
    parameter int GAIN_SHIFT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          smp_tick,
    input  logic [VOICES*PCM_W-1:0]       voice_pcm,
    input  logic [VOICES*(PCM_W-1)-1:0]   voice_env,
    input  logic [VOICES-1:0]             voice_ena,
    output logic [PCM_W-1:0]              mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          clip,
    output logic                          ovr
);

    localparam int c_acc_w = PCM_W + $clog2(VOICES) + 1;
    localparam int c_idx_w = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(VOICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [VOICES*PCM_W-1:0]         r_pcm;
    logic [VOICES*(PCM_W-1)-1:0]     r_env;
    logic [VOICES-1:0]               r_ena;
    logic signed [c_acc_w-1:0]       r_acc;
    logic [c_idx_w-1:0]              r_idx;
    logic [PCM_W-1:0]                r_mix;
    logic                            r_valid;
    logic                            r_ovr;

    logic signed [PCM_W-1:0]         w_pcm_arr [VOICES];
    logic        [PCM_W-2:0]         w_env_arr [VOICES];
    logic signed [PCM_W-1:0]         w_pcm_sel;
    logic        [PCM_W-2:0]         w_env_sel;
    logic signed [2*PCM_W-1:0]       w_prod;
    logic signed [PCM_W-1:0]         w_term;
    logic signed [c_acc_w-1:0]       w_term_ext;
    logic        [PCM_W-1:0]         w_res;
    logic                            w_ovf;

    for (genvar k = 0; k < VOICES; k++) begin : g_unpack
        assign w_pcm_arr[k] = r_pcm[k*PCM_W +: PCM_W];
        assign w_env_arr[k] = r_env[k*(PCM_W-1) +: PCM_W-1];
    end

    // Envelope is treated as a positive fraction: zero-extend before the signed multiply
    assign w_pcm_sel  = w_pcm_arr[r_idx];
    assign w_env_sel  = w_env_arr[r_idx];
    assign w_prod     = w_pcm_sel * $signed({1'b0, w_env_sel});
    assign w_term     = r_ena[r_idx] ? PCM_W'(w_prod >>> (PCM_W - 1)) : '0;
    assign w_term_ext = {{(c_acc_w-PCM_W){w_term[PCM_W-1]}}, w_term};

`ifdef VOICE_MIX_SAT_EN
    logic signed [c_acc_w-1:0]       w_shift;
    logic        [c_acc_w-PCM_W:0]   w_upper;
    logic                            r_clip;

    assign w_shift = r_acc >>> GAIN_SHIFT;
    assign w_upper = w_shift[c_acc_w-1:PCM_W-1];
    // Out of range whenever the bits above the result sign are not a pure sign extension
    assign w_ovf   = !((&w_upper) || !(|w_upper));
    assign w_res   = !w_ovf ? w_shift[PCM_W-1:0] :
                     (w_shift[c_acc_w-1] ? {1'b1, {(PCM_W-1){1'b0}}}
                                         : {1'b0, {(PCM_W-1){1'b1}}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip <= 1'b0;
        end else begin
            r_clip <= (r_state == OUT) && w_ovf;
        end
    end

    assign clip = r_clip;
`else
    assign w_ovf = 1'b0;
    assign w_res = PCM_W'(r_acc >>> GAIN_SHIFT);
    assign clip  = w_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (smp_tick) w_next = ACC;
            ACC:     if (r_idx == c_last) w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcm   <= '0;
            r_env   <= '0;
            r_ena   <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_mix   <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (smp_tick && (r_state != IDLE)) begin
                r_ovr <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (smp_tick) begin
                        r_pcm <= voice_pcm;
                        r_env <= voice_env;
                        r_ena <= voice_ena;
                        r_acc <= '0;
                        r_idx <= '0;
                    end
                end
                ACC: begin
                    r_acc <= r_acc + w_term_ext;
                    r_idx <= (r_idx == c_last) ? '0 : r_idx + 1'b1;
                end
                OUT: begin
                    r_mix   <= w_res;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mix_out   = r_mix;
    assign mix_valid = r_valid;
    assign busy      = (r_state != IDLE);
    assign ovr       = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_voice_mix.sv
// ============================================================================
// Module      : tb_voice_mix
// Description : Self-checking bench for voice_mix (GAIN_SHIFT=2 and =0 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_mix;

    logic        clk;
    logic        rst_n;
    logic        smp_tick;
    logic [63:0] voice_pcm;
    logic [59:0] voice_env;
    logic [3:0]  voice_ena;

    logic [15:0] mix_out2, mix_out0;
    logic        mix_valid2, mix_valid0;
    logic        busy2, busy0;
    logic        clip2, clip0;
    logic        ovr2, ovr0;

    int m_pcm [4];
    int m_env [4];
    bit m_ena [4];

    int n_vec;
    int n_err;

    voice_mix #(.PCM_W(16), .VOICES(4), .GAIN_SHIFT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .smp_tick(smp_tick),
        .voice_pcm(voice_pcm), .voice_env(voice_env), .voice_ena(voice_ena),
        .mix_out(mix_out2), .mix_valid(mix_valid2), .busy(busy2),
        .clip(clip2), .ovr(ovr2)
    );

    voice_mix #(.PCM_W(16), .VOICES(4), .GAIN_SHIFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .smp_tick(smp_tick),
        .voice_pcm(voice_pcm), .voice_env(voice_env), .voice_ena(voice_ena),
        .mix_out(mix_out0), .mix_valid(mix_valid0), .busy(busy0),
        .clip(clip0), .ovr(ovr0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: each term is floor(pcm*env / 2^15), the sum is exact, then shift and reduce.
    function automatic longint model_sum();
        longint s = 0;
        for (int k = 0; k < 4; k++) begin
            if (m_ena[k]) s += (longint'(m_pcm[k]) * longint'(m_env[k])) >>> 15;
        end
        return s;
    endfunction

    function automatic void model_out(input int gs, output int res, output bit clp);
        longint sh;
        logic signed [15:0] lo;
        sh = model_sum() >>> gs;
`ifdef VOICE_MIX_SAT_EN
        clp = 1'b1;
        if (sh > 32767)       res = 32767;
        else if (sh < -32768) res = -32768;
        else begin
            res = int'(sh);
            clp = 1'b0;
        end
`else
        lo  = sh[15:0];
        res = int'(lo);
        clp = 1'b0;
`endif
    endfunction

    task automatic drive_ports();
        int p, e;
        for (int k = 0; k < 4; k++) begin
            p = m_pcm[k];
            e = m_env[k];
            voice_pcm[k*16 +: 16] = p[15:0];
            voice_env[k*15 +: 15] = e[14:0];
            voice_ena[k]          = m_ena[k];
        end
    endtask

    task automatic scramble_ports();
        voice_pcm = {$urandom, $urandom};
        voice_env = {$urandom, $urandom};
        voice_ena = 4'($urandom);
    endtask

    task automatic set_all(input int p, input int e, input logic [3:0] ena);
        for (int k = 0; k < 4; k++) begin
            m_pcm[k] = p;
            m_env[k] = e;
            m_ena[k] = ena[k];
        end
    endtask

    task automatic run_frame(input string tag);
        int  e2, e0, lat;
        bit  c2, c0, seen;
        model_out(2, e2, c2);
        model_out(0, e0, c0);
        @(negedge clk);
        drive_ports();
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        scramble_ports();
        n_vec++;
        if (busy2 !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_after_tick: got %0b expected 1", tag, busy2);
        end
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (mix_valid2 === 1'b1) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        n_vec++;
        if (!seen || lat != 5) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles (seen=%0b) expected 5", tag, lat, seen);
        end
        if (seen) begin
            n_vec++;
            if (int'($signed(mix_out2)) != e2) begin
                n_err++;
                $display("FAIL %s mix_out_gs2: got %0d expected %0d", tag, $signed(mix_out2), e2);
            end
            n_vec++;
            if (clip2 !== c2) begin
                n_err++;
                $display("FAIL %s clip_gs2: got %0b expected %0b", tag, clip2, c2);
            end
            n_vec++;
            if (mix_valid0 !== 1'b1 || int'($signed(mix_out0)) != e0) begin
                n_err++;
                $display("FAIL %s mix_out_gs0: got %0d (valid %0b) expected %0d", tag, $signed(mix_out0), mix_valid0, e0);
            end
            n_vec++;
            if (clip0 !== c0) begin
                n_err++;
                $display("FAIL %s clip_gs0: got %0b expected %0b", tag, clip0, c0);
            end
            @(negedge clk);
            n_vec++;
            if (mix_valid2 !== 1'b0 || busy2 !== 1'b0 || clip2 !== 1'b0) begin
                n_err++;
                $display("FAIL %s strobe_end: valid %0b busy %0b clip %0b expected 0 0 0", tag, mix_valid2, busy2, clip2);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        smp_tick  = 1'b0;
        voice_pcm = '0;
        voice_env = '0;
        voice_ena = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (mix_out2 !== 16'h0 || mix_valid2 !== 1'b0 || busy2 !== 1'b0 ||
            clip2 !== 1'b0 || ovr2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: out %h valid %0b busy %0b clip %0b ovr %0b expected all 0",
                     mix_out2, mix_valid2, busy2, clip2, ovr2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        set_all(16'sh4000, 16'h7FFF, 4'hF);
        run_frame("full_half");
        n_vec++;
        if (int'($signed(mix_out2)) != 16383) begin
            n_err++;
            $display("FAIL full_half_const: got %0d expected 16383", $signed(mix_out2));
        end
        set_all(16'sh4000, 16'h7FFF, 4'b0010);
        run_frame("one_voice");
        n_vec++;
        if (int'($signed(mix_out2)) != 4095) begin
            n_err++;
            $display("FAIL one_voice_const: got %0d expected 4095", $signed(mix_out2));
        end
        set_all(32767, 32767, 4'hF);
        run_frame("pos_overflow");
        n_vec++;
`ifdef VOICE_MIX_SAT_EN
        if (int'($signed(mix_out0)) != 32767) begin
            n_err++;
            $display("FAIL pos_overflow_const: got %0d expected 32767", $signed(mix_out0));
        end
`else
        if (int'($signed(mix_out0)) != -8) begin
            n_err++;
            $display("FAIL pos_overflow_const: got %0d expected -8", $signed(mix_out0));
        end
`endif
        set_all(-32768, 32767, 4'hF);
        run_frame("neg_overflow");
        n_vec++;
`ifdef VOICE_MIX_SAT_EN
        if (int'($signed(mix_out0)) != -32768) begin
            n_err++;
            $display("FAIL neg_overflow_const: got %0d expected -32768", $signed(mix_out0));
        end
`else
        if (int'($signed(mix_out0)) != 4) begin
            n_err++;
            $display("FAIL neg_overflow_const: got %0d expected 4", $signed(mix_out0));
        end
`endif
    endtask

    task automatic test_random();
        logic signed [15:0] s;
        for (int f = 0; f < 24; f++) begin
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 5))
                    0:       m_pcm[k] = 32767;
                    1:       m_pcm[k] = -32768;
                    default: begin s = 16'($urandom); m_pcm[k] = int'(s); end
                endcase
                m_env[k] = ($urandom_range(0, 3) == 0) ? 32767 : int'($urandom_range(0, 32767));
                m_ena[k] = 1'($urandom);
            end
            run_frame("random");
        end
    endtask

    task automatic test_overrun();
        int nvalid, got;
        do_reset();
        n_vec++;
        if (ovr2 !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got %0b expected 0", ovr2);
        end
        set_all(16'sh4000, 16'h7FFF, 4'hF);
        @(negedge clk);
        drive_ports();
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        @(negedge clk);
        scramble_ports();
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        nvalid = 0;
        got    = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (mix_valid2 === 1'b1) begin
                nvalid++;
                got = int'($signed(mix_out2));
            end
        end
        n_vec++;
        if (nvalid != 1) begin
            n_err++;
            $display("FAIL overrun_valid_count: got %0d expected 1", nvalid);
        end
        n_vec++;
        if (got != 16383) begin
            n_err++;
            $display("FAIL overrun_value: got %0d expected 16383", got);
        end
        n_vec++;
        if (ovr2 !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_flag: got %0b expected 1", ovr2);
        end
        set_all(1000, 20000, 4'b1011);
        run_frame("after_overrun");
        n_vec++;
        if (ovr2 !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: got %0b expected 1", ovr2);
        end
    endtask

    task automatic test_reset_abort();
        int nvalid;
        set_all(16'sh4000, 16'h7FFF, 4'hF);
        run_frame("pre_abort");
        set_all(-20000, 30000, 4'b0111);
        @(negedge clk);
        drive_ports();
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy2 !== 1'b0 || mix_out2 !== 16'h0 || ovr2 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_immediate: busy %0b out %h ovr %0b expected 0 0000 0", busy2, mix_out2, ovr2);
        end
        nvalid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mix_valid2 !== 1'b0) nvalid++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mix_valid2 !== 1'b0) nvalid++;
        end
        n_vec++;
        if (nvalid != 0) begin
            n_err++;
            $display("FAIL abort_no_valid: got %0d strobes expected 0", nvalid);
        end
        set_all(12345, 23456, 4'b1101);
        run_frame("post_abort");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_random();
        test_overrun();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
